// File: rtl/maroc_sc_scheduler_if.sv
// Register-interface and transmitter-side signal bundle for maroc_sc_scheduler.
//
// slave  : the scheduler side (takes requests and transmitter state, drives
//          start/reset/mux/strobes and status).
// master : the surrounding logic (register block + transmitter glue).
//
// Signals:
//   host_req_in     single-cycle host configuration request
//   refresh_en_in   enables the periodic refresh timer
//   clear_err_in    clears the sticky error flag
//   tx_state_in     transmitter state: 0 idle, 1 reset, 2 shift, 3 done
//   tx_start_out    one-cycle transmitter start pulse
//   tx_reset_out    transmitter reset during recovery (2 cycles)
//   src_sel_out     frame source select: 0 host registers, 1 shadow config
//   latch_cfg_out   one-cycle snapshot strobe for the selected source
//   busy_out        high whenever the scheduler is not idle
//   done_out        one-cycle pulse per successful frame
//   err_out         sticky: retries exhausted
//   frame_cnt_out   successful frame counter (wraps)
//   sched_state_out scheduler FSM state
interface maroc_sc_scheduler_if;
    logic        host_req_in;
    logic        refresh_en_in;
    logic        clear_err_in;
    logic [1:0]  tx_state_in;
    logic        tx_start_out;
    logic        tx_reset_out;
    logic        src_sel_out;
    logic        latch_cfg_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;
    logic [15:0] frame_cnt_out;
    logic [2:0]  sched_state_out;

    modport slave (
        input  host_req_in, refresh_en_in, clear_err_in, tx_state_in,
        output tx_start_out, tx_reset_out, src_sel_out, latch_cfg_out,
               busy_out, done_out, err_out, frame_cnt_out, sched_state_out
    );

    modport master (
        output host_req_in, refresh_en_in, clear_err_in, tx_state_in,
        input  tx_start_out, tx_reset_out, src_sel_out, latch_cfg_out,
               busy_out, done_out, err_out, frame_cnt_out, sched_state_out
    );
endinterface

// File: rtl/maroc_sc_scheduler.sv
// maroc_sc_scheduler: shares the MAROC slow-control serial link between host
// configuration writes and a periodic shadow-config refresh. Issues the
// transmitter start pulse, tracks completion through the transmitter state,
// and recovers stalled frames with a watchdog, bounded retries and a
// transmitter reset.
//
// Ports:
//   clk_in    system clock (same clock as the transmitter)
//   reset_in  synchronous active-high reset
//   sc        maroc_sc_scheduler_if.slave (requests, transmitter state,
//             transmitter controls, status)
module maroc_sc_scheduler #(
    parameter int REFRESH_CYCLES = 5000000,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int GAP_CYCLES     = 16,
    parameter int MAX_RETRY      = 2
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    maroc_sc_scheduler_if.slave  sc
);

    localparam int REF_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LATCH     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5,
        ST_RECOVER   = 3'd6
    } state_t;

    state_t             state_reg, state_next;
    logic [REF_W-1:0]   ref_cnt_reg, ref_cnt_next;
    logic [WD_W-1:0]    wd_reg, wd_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic [RTY_W-1:0]   retry_reg, retry_next;
    logic               rec_reg, rec_next;
    logic               host_pend_reg, host_pend_next;
    logic               ref_pend_reg, ref_pend_next;
    logic               src_sel_reg, src_sel_next;
    logic               err_reg, err_next;
    logic [15:0]        frame_cnt_reg, frame_cnt_next;
    logic               tx_start_reg, tx_reset_reg, latch_reg, busy_reg, done_reg;

    logic               grant_host, grant_ref, frame_done, err_set, ref_tick;

    // Scheduler FSM: next state and per-state bookkeeping.
    always_comb begin
        state_next   = state_reg;
        wd_next      = wd_reg;
        gap_next     = gap_reg;
        rec_next     = rec_reg;
        retry_next   = retry_reg;
        src_sel_next = src_sel_reg;
        grant_host   = 1'b0;
        grant_ref    = 1'b0;
        frame_done   = 1'b0;
        err_set      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (host_pend_reg) begin
                    grant_host   = 1'b1;
                    src_sel_next = 1'b0;
                    retry_next   = '0;
                    state_next   = ST_LATCH;
                end else if (ref_pend_reg) begin
                    grant_ref    = 1'b1;
                    src_sel_next = 1'b1;
                    retry_next   = '0;
                    state_next   = ST_LATCH;
                end
            end
            ST_LATCH: state_next = ST_START;
            ST_START: begin
                wd_next    = '0;
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
                // Done is checked first so a frame finishing on the last
                // watchdog cycle still counts; a done seen while waiting for
                // busy also counts (very short frames).
                if (sc.tx_state_in == 2'd3) begin
                    frame_done = 1'b1;
                    gap_next   = '0;
                    state_next = ST_GAP;
                end else if (wd_reg == WD_LAST) begin
                    rec_next   = 1'b0;
                    state_next = ST_RECOVER;
                end else begin
                    wd_next = wd_reg + 1'b1;
                    if (state_reg == ST_WAIT_BUSY && sc.tx_state_in != 2'd0)
                        state_next = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                // The entry cycle (done / error cycle) is followed by
                // GAP_CYCLES idle cycles before IDLE can grant again.
                if (gap_reg == GAP_LAST)
                    state_next = ST_IDLE;
                else
                    gap_next = gap_reg + 1'b1;
            end
            ST_RECOVER: begin
                if (rec_reg) begin
                    if (retry_reg < RTY_MAX) begin
                        retry_next = retry_reg + 1'b1;
                        state_next = ST_LATCH;
                    end else begin
                        err_set    = 1'b1;
                        gap_next   = '0;
                        state_next = ST_GAP;
                    end
                end else begin
                    rec_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, refresh timer, status.
    always_comb begin
        ref_tick     = 1'b0;
        ref_cnt_next = ref_cnt_reg;
        if (!sc.refresh_en_in) begin
            ref_cnt_next = '0;
        end else if (ref_cnt_reg == REF_LAST) begin
            ref_cnt_next = '0;
            ref_tick     = 1'b1;
        end else begin
            ref_cnt_next = ref_cnt_reg + 1'b1;
        end
        // A request on the grant cycle re-arms the flag so it is not lost.
        host_pend_next = (host_pend_reg & ~grant_host) | sc.host_req_in;
        ref_pend_next  = (ref_pend_reg & ~grant_ref) | ref_tick;
        // A new error beats a simultaneous clear.
        err_next       = err_set | (err_reg & ~sc.clear_err_in);
        frame_cnt_next = frame_cnt_reg + 16'(frame_done);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg     <= ST_IDLE;
            ref_cnt_reg   <= '0;
            wd_reg        <= '0;
            gap_reg       <= '0;
            retry_reg     <= '0;
            rec_reg       <= 1'b0;
            host_pend_reg <= 1'b0;
            ref_pend_reg  <= 1'b0;
            src_sel_reg   <= 1'b0;
            err_reg       <= 1'b0;
            frame_cnt_reg <= '0;
            tx_start_reg  <= 1'b0;
            tx_reset_reg  <= 1'b0;
            latch_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ref_cnt_reg   <= ref_cnt_next;
            wd_reg        <= wd_next;
            gap_reg       <= gap_next;
            retry_reg     <= retry_next;
            rec_reg       <= rec_next;
            host_pend_reg <= host_pend_next;
            ref_pend_reg  <= ref_pend_next;
            src_sel_reg   <= src_sel_next;
            err_reg       <= err_next;
            frame_cnt_reg <= frame_cnt_next;
            // Strobes are decoded from the next state so they are flops
            // aligned with the state they belong to.
            tx_start_reg  <= (state_next == ST_START);
            tx_reset_reg  <= (state_next == ST_RECOVER);
            latch_reg     <= (state_next == ST_LATCH);
            busy_reg      <= (state_next != ST_IDLE);
            done_reg      <= frame_done;
        end
    end

    assign sc.tx_start_out    = tx_start_reg;
    assign sc.tx_reset_out    = tx_reset_reg;
    assign sc.src_sel_out     = src_sel_reg;
    assign sc.latch_cfg_out   = latch_reg;
    assign sc.busy_out        = busy_reg;
    assign sc.done_out        = done_reg;
    assign sc.err_out         = err_reg;
    assign sc.frame_cnt_out   = frame_cnt_reg;
    assign sc.sched_state_out = state_reg;

endmodule

// File: tb/tb_maroc_sc_scheduler.sv
// Self-checking bench for maroc_sc_scheduler with a behavioural transmitter
// model and a timeline reference computed from the scheduler's rules.
module tb_maroc_sc_scheduler;
    localparam int REFRESH = 4000;
    localparam int TIMEOUT = 1200;
    localparam int GAP     = 16;
    localparam int RETRY   = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_frames = 0;

    maroc_sc_scheduler_if sc();

    maroc_sc_scheduler #(
        .REFRESH_CYCLES(REFRESH),
        .TIMEOUT_CYCLES(TIMEOUT),
        .GAP_CYCLES(GAP),
        .MAX_RETRY(RETRY)
    ) dut (
        .clk_in(clk),
        .reset_in(rst),
        .sc(sc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log of DUT strobes, sampled mid-cycle.
    int latch_q[$];
    int src_q[$];
    int start_q[$];
    int done_q[$];
    int treset_q[$];

    always @(negedge clk) begin
        if (sc.latch_cfg_out === 1'b1) begin
            latch_q.push_back(cyc);
            src_q.push_back(int'(sc.src_sel_out));
        end
        if (sc.tx_start_out === 1'b1) start_q.push_back(cyc);
        if (sc.done_out === 1'b1)     done_q.push_back(cyc);
        if (sc.tx_reset_out === 1'b1) treset_q.push_back(cyc);
    end

    // Transmitter model: after a start it shifts, then reports done from
    // the model_k-th cycle after the start for 4 cycles, then returns idle.
    int model_k = 840;
    int mk = 0;
    int mc = 0;
    bit mact = 1'b0;

    always @(negedge clk) begin
        if (sc.tx_reset_out === 1'b1) begin
            mact = 1'b0;
            sc.tx_state_in = 2'd0;
        end else if (sc.tx_start_out === 1'b1) begin
            mact = 1'b1;
            mc = 0;
            mk = model_k;
            sc.tx_state_in = 2'd1;
        end else if (mact) begin
            mc++;
            if (mc < mk)          sc.tx_state_in = 2'd2;
            else if (mc < mk + 4) sc.tx_state_in = 2'd3;
            else begin
                sc.tx_state_in = 2'd0;
                mact = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_log();
        latch_q.delete(); src_q.delete(); start_q.delete();
        done_q.delete(); treset_q.delete();
    endtask

    task automatic pulse_host();
        sc.host_req_in = 1'b1;
        @(negedge clk);
        sc.host_req_in = 1'b0;
    endtask

    // Wait until busy has been low for 24 consecutive cycles.
    task automatic wait_quiet(input string tag, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 24 && n < budget) begin
            @(negedge clk);
            n++;
            quiet = (sc.busy_out === 1'b1) ? 0 : quiet + 1;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    // One host frame from an idle scheduler, checked against the timeline.
    task automatic host_frame(input string tag, input int k);
        int r;
        model_k = k;
        clear_log();
        r = cyc;
        pulse_host();
        wait_quiet({tag, "_quiet"}, 4000);
        exp_frames = (exp_frames + 1) % 65536;
        check({tag, "_latch"}, 32'(qat(latch_q, 0)), 32'(r + 2));
        check({tag, "_start"}, 32'(qat(start_q, 0)), 32'(r + 3));
        check({tag, "_done"},  32'(qat(done_q, 0)), 32'(r + 3 + k + 1));
        check({tag, "_ndone"}, 32'(done_q.size()), 32'd1);
        check({tag, "_nreset"}, 32'(treset_q.size()), 32'd0);
        check({tag, "_cnt"}, 32'(sc.frame_cnt_out), 32'(exp_frames));
        $display("frame %s k=%0d req=%0d start=%0d done=%0d cnt=%0d",
                 tag, k, r, qat(start_q, 0), qat(done_q, 0), sc.frame_cnt_out);
    endtask

    initial begin
        int r, e, k, s;
        rst = 1'b1;
        sc.host_req_in = 1'b0;
        sc.refresh_en_in = 1'b0;
        sc.clear_err_in = 1'b0;
        sc.tx_state_in = 2'd0;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_state", 32'(sc.sched_state_out), 32'd0);
        check("rst_cnt", 32'(sc.frame_cnt_out), 32'd0);
        check("rst_strobes", 32'({sc.tx_start_out, sc.tx_reset_out, sc.src_sel_out,
              sc.latch_cfg_out, sc.busy_out, sc.done_out, sc.err_out}), 32'd0);

        // Host request at cycle 10, refresh disabled, 840-cycle frame
        while (cyc < 10) @(negedge clk);
        host_frame("host10", 840);
        check("host10_src", 32'(qat(src_q, 0)), 32'd0);
        check("host10_busy", 32'(sc.busy_out), 32'd0);

        // Random frames including done in WAIT_BUSY and done on timeout cycle
        for (int i = 0; i < 4; i++) begin
            k = (i == 0) ? 1 : (i == 1) ? TIMEOUT : int'($urandom_range(2, TIMEOUT - 1));
            repeat ($urandom_range(0, 30)) @(negedge clk);
            host_frame($sformatf("rnd%0d", i), k);
        end

        // Host request on the same cycle as the refresh tick
        k = int'($urandom_range(700, 1100));
        model_k = k;
        clear_log();
        e = cyc;
        sc.refresh_en_in = 1'b1;
        repeat (REFRESH - 1) @(negedge clk);
        pulse_host();
        wait_quiet("coll_quiet", 6000);
        sc.refresh_en_in = 1'b0;
        exp_frames += 2;
        check("coll_nlatch", 32'(latch_q.size()), 32'd2);
        check("coll_latch0", 32'(qat(latch_q, 0)), 32'(e + REFRESH + 1));
        check("coll_src0", 32'(qat(src_q, 0)), 32'd0);
        check("coll_src1", 32'(qat(src_q, 1)), 32'd1);
        check("coll_done0", 32'(qat(done_q, 0)), 32'(e + REFRESH + 2 + k + 1));
        check("coll_gap", 32'(qat(start_q, 1) - qat(done_q, 0) >= GAP + 3), 32'd1);
        check("coll_done1", 32'(qat(done_q, 1)), 32'(qat(start_q, 1) + k + 1));
        check("coll_cnt", 32'(sc.frame_cnt_out), 32'(exp_frames));
        $display("collision tick=%0d starts=%0d,%0d dones=%0d,%0d",
                 e + REFRESH - 1, qat(start_q, 0), qat(start_q, 1), qat(done_q, 0), qat(done_q, 1));

        // Three host requests merged into one pending frame
        k = int'($urandom_range(700, 1100));
        model_k = k;
        clear_log();
        pulse_host();
        s = 0;
        while (sc.tx_start_out !== 1'b1 && s < 100) begin @(negedge clk); s++; end
        check("merge_start_seen", 32'(s < 100), 32'd1);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(5, 100)) @(negedge clk);
            pulse_host();
        end
        wait_quiet("merge_quiet", 5000);
        exp_frames += 2;
        check("merge_nstart", 32'(start_q.size()), 32'd2);
        check("merge_ndone", 32'(done_q.size()), 32'd2);
        check("merge_src1", 32'(qat(src_q, 1)), 32'd0);
        check("merge_gap", 32'(qat(start_q, 1) - qat(done_q, 0) >= GAP + 3), 32'd1);
        check("merge_cnt", 32'(sc.frame_cnt_out), 32'(exp_frames));
        $display("merged starts=%0d dones=%0d", start_q.size(), done_q.size());

        // Stalled transmitter: all attempts time out
        model_k = 100000;
        clear_log();
        r = cyc;
        pulse_host();
        repeat (2 * TIMEOUT + 8) @(negedge clk);
        check("stall_err_early", 32'(sc.err_out), 32'd0);
        wait_quiet("stall_quiet", 6000);
        check("stall_nstart", 32'(start_q.size()), 32'(RETRY + 1));
        check("stall_nlatch", 32'(latch_q.size()), 32'(RETRY + 1));
        check("stall_ndone", 32'(done_q.size()), 32'd0);
        check("stall_nreset", 32'(treset_q.size()), 32'(2 * (RETRY + 1)));
        for (int i = 0; i <= RETRY; i++) begin
            s = r + 3 + i * (TIMEOUT + 4);
            check($sformatf("stall_start%0d", i), 32'(qat(start_q, i)), 32'(s));
            check($sformatf("stall_rst%0da", i), 32'(qat(treset_q, 2 * i)), 32'(s + TIMEOUT + 1));
            check($sformatf("stall_rst%0db", i), 32'(qat(treset_q, 2 * i + 1)), 32'(s + TIMEOUT + 2));
            check($sformatf("stall_src%0d", i), 32'(qat(src_q, i)), 32'd0);
        end
        check("stall_err", 32'(sc.err_out), 32'd1);
        check("stall_cnt", 32'(sc.frame_cnt_out), 32'(exp_frames));
        $display("stall starts=%0d resets=%0d err=%0d", start_q.size(), treset_q.size(), sc.err_out);

        sc.clear_err_in = 1'b1;
        @(negedge clk);
        sc.clear_err_in = 1'b0;
        check("clear_err", 32'(sc.err_out), 32'd0);
        host_frame("after_err", int'($urandom_range(300, 1100)));

        // Reset during WAIT_DONE
        model_k = 900;
        clear_log();
        pulse_host();
        s = 0;
        while (sc.sched_state_out !== 3'd4 && s < 100) begin @(negedge clk); s++; end
        check("mid_wait_done_seen", 32'(s < 100), 32'd1);
        repeat ($urandom_range(10, 300)) @(negedge clk);
        rst = 1'b1;
        mact = 1'b0;
        sc.tx_state_in = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_outputs", 32'({sc.tx_start_out, sc.tx_reset_out, sc.src_sel_out,
              sc.latch_cfg_out, sc.busy_out, sc.done_out, sc.err_out,
              sc.frame_cnt_out, sc.sched_state_out}), 32'd0);
        check("mid_rst_nreset", 32'(treset_q.size()), 32'd0);
        exp_frames = 0;
        repeat (5) @(negedge clk);
        host_frame("after_rst", int'($urandom_range(300, 1100)));

        // Frame counter wrap
        force dut.frame_cnt_reg = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt_reg;
        @(negedge clk);
        check("wrap_preset", 32'(sc.frame_cnt_out), 32'hFFFF);
        exp_frames = 16'hFFFF;
        host_frame("wrap", int'($urandom_range(300, 1100)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/maroc_sc_scheduler.md
# maroc_sc_scheduler

Sequencer and arbiter in front of the MAROC slow-control `transmitter`. It shares the single 829-bit serial configuration link between two frame sources: a host write request and a periodic refresh of the shadow configuration. It issues the transmitter start pulse and tracks frame completion via the transmitter's `state_out`. A watchdog with bounded retry and transmitter reset handles stalled frames, and the block reports status to the register interface.

## Interface
Parameters:
- `REFRESH_CYCLES`, default 5000000: clk_in cycles between periodic refresh requests (1 s at 5 MHz).
- `TIMEOUT_CYCLES`, default 2048: maximum cycles from start pulse to observed frame done.
- `GAP_CYCLES`, default 16: idle cycles enforced after every frame attempt, before the next grant.
- `MAX_RETRY`, default 2: retries after a timeout before the request is dropped.

Ports:
- `clk_in` input 1: system clock, 5 MHz, same clock as the transmitter.
- `reset_in` input 1: one clock; reset is synchronous and active-high.
- `host_req_in` input 1: single-cycle request to send the host configuration.
- `refresh_en_in` input 1: enables the refresh timer.
- `clear_err_in` input 1: clears `err_out`.
- `tx_state_in` input 2: transmitter `state_out`, encoded 0 idle, 1 reset, 2 shift, 3 done.
- `tx_start_out` output 1: one-cycle start pulse to the transmitter `start_in`.
- `tx_reset_out` output 1: transmitter reset, held high for 2 cycles during recovery.
- `src_sel_out` output 1: frame source mux select, 0 host registers, 1 shadow config; stable from latch until the frame ends.
- `latch_cfg_out` output 1: one-cycle snapshot strobe for the selected source registers.
- `busy_out` output 1: high in every state except IDLE.
- `done_out` output 1: one-cycle pulse on successful frame completion.
- `err_out` output 1: sticky; set when retries are exhausted.
- `frame_cnt_out` output 16: successful frames sent; wraps from 0xFFFF to 0.
- `sched_state_out` output 3: FSM state.

## Operation
- Pending flags:
  - `host_pend` is set by `host_req_in`.
  - `ref_pend` is set when the refresh counter reaches `REFRESH_CYCLES-1`; the counter then reloads to 0.
  - Each flag is single-depth. A request that arrives while its flag is already set is merged.
- `refresh_en_in` low holds the refresh counter at 0. An existing `ref_pend` is kept.
- Arbitration happens in IDLE only. `host_pend` has priority over `ref_pend`. The granted flag is cleared on the grant cycle; the other flag stays set.
- A request arriving on the same cycle its flag is cleared re-sets the flag, so the request is not lost.
- FSM states and transitions:
  - IDLE (0): if any flag is pending, go to LATCH.
  - LATCH (1): drive `src_sel_out`, pulse `latch_cfg_out`, go to START.
  - START (2): pulse `tx_start_out`, clear the watchdog, go to WAIT_BUSY.
  - WAIT_BUSY (3): wait for `tx_state_in` != 0, then go to WAIT_DONE.
  - WAIT_DONE (4): on `tx_state_in` == 3, pulse `done_out`, increment `frame_cnt_out`, go to GAP.
  - GAP (5): count `GAP_CYCLES`, then go to IDLE.
  - RECOVER (6): hold `tx_reset_out` for 2 cycles.
- Watchdog: counts every cycle in WAIT_BUSY and WAIT_DONE. When it reaches `TIMEOUT_CYCLES`, go to RECOVER.
- After RECOVER:
  - If retry < `MAX_RETRY`: increment retry, go to LATCH with the same `src_sel_out`.
  - Otherwise: set `err_out`, drop the request, go to GAP.
- The retry counter clears on every grant.
- `clear_err_in` clears `err_out`. If `clear_err_in` and a new error occur in the same cycle, the set wins.
- `err_out` does not block scheduling.

## Timing
- Reset values:
  - All outputs are 0.
  - `sched_state_out` = IDLE.
  - `frame_cnt_out` = 0.
  - Pending flags, refresh counter, watchdog and retry counter are all 0.
- Reset mid-frame aborts immediately and does not pulse `tx_reset_out`. The system reset also resets the transmitter.
- Latency from `host_req_in` (cycle N, FSM in IDLE):
  - flag set at N+1
  - LATCH at N+2
  - `tx_start_out` high during cycle N+3
- `done_out` rises in the cycle after `tx_state_in` == 3 is first sampled.
- Done detection is first-sample only. The block does not require the transmitter to return to idle.
- The next `tx_start_out` comes at least `GAP_CYCLES`+3 cycles after `done_out`.
- If `tx_state_in` == 3 is sampled in WAIT_BUSY, it counts as done.
- Done and timeout in the same cycle: done wins.
- All outputs are registered.

## Test plan
Bench parameters: `REFRESH_CYCLES`=4000, `TIMEOUT_CYCLES`=1200, `GAP_CYCLES`=16, `MAX_RETRY`=2; transmitter model completes a frame in 840 cycles.
- Host request with refresh disabled:
  - Stimulus: `host_req_in` pulse at cycle 10.
  - Required: `latch_cfg_out` at 12 with `src_sel_out`=0; `tx_start_out` at 13; one `done_out`; `frame_cnt_out`=1; `busy_out` low after GAP.
- Host and refresh collision:
  - Stimulus: refresh enabled; `host_req_in` on the same cycle as the refresh tick.
  - Required: host frame first (`src_sel_out`=0), then a refresh frame (`src_sel_out`=1) after 16 idle cycles; `frame_cnt_out`=2.
- Merged requests:
  - Stimulus: 3 `host_req_in` pulses during one busy frame.
  - Required: exactly one additional host frame.
- Stalled transmitter:
  - Stimulus: model holds `tx_state_in`=2.
  - Required: 3 start pulses, each followed by `tx_reset_out` high for 2 cycles after 1200 cycles; then `err_out`=1, no `done_out`.
  - Follow-up: `clear_err_in` clears `err_out`; a following host frame succeeds.
- Reset mid-shift and counter wrap:
  - Stimulus: `reset_in` asserted during WAIT_DONE.
  - Required: all outputs 0 on the next cycle; a new request works normally.
  - Stimulus: `frame_cnt_out` forced to 0xFFFF, then one success.
  - Required: `frame_cnt_out` reads 0.
